cursor_motion: RTL and testbench

//  Downstream consumer of the joystick direction classifier. Takes per-axis speed codes
//  (dir = vertical, LRdir = horizontal) and integrates them into a clamped on-screen

---
 rtl/motion_pkg.sv | 47 ++++
 rtl/axis_integrator.sv | 46 ++++
 rtl/cursor_motion.sv | 95 +++++++++
 tb/tb_cursor_motion.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// Shared codes, FSM encoding and code-to-step helpers for the cursor motion block.
package motion_pkg;

  localparam logic [2:0] DIR_NONE    = 3'd0;
  localparam logic [2:0] DIR_UP_SLOW = 3'd1;
  localparam logic [2:0] DIR_DN_SLOW = 3'd2;
  localparam logic [2:0] DIR_DN_FAST = 3'd3;
  localparam logic [2:0] DIR_UP_FAST = 3'd4;

  localparam logic [2:0] LR_NONE = 3'd0;
  localparam logic [2:0] LR_SLOW = 3'd1;
  localparam logic [2:0] LR_FAST = 3'd2;

  localparam logic signed [10:0] SLOW_STEP = 11'sd1;
  localparam logic signed [10:0] FAST_STEP = 11'sd4;

  typedef enum logic {IDLE, MOVE} state_t;

  // Codes outside the legal set behave exactly like "no motion".
  function automatic logic [2:0] dir_clean(input logic [2:0] code);
    return (code > DIR_UP_FAST) ? DIR_NONE : code;
  endfunction

  function automatic logic [2:0] lr_clean(input logic [2:0] code);
    return (code > LR_FAST) ? LR_NONE : code;
  endfunction

  // Vertical step; y grows downward so "up" is negative.
  function automatic logic signed [10:0] dir_step(input logic [2:0] code);
    case (code)
      DIR_UP_SLOW: return -SLOW_STEP;
      DIR_UP_FAST: return -FAST_STEP;
      DIR_DN_SLOW: return SLOW_STEP;
      DIR_DN_FAST: return FAST_STEP;
      default:     return '0;
    endcase
  endfunction

  function automatic logic signed [10:0] lr_step(input logic [2:0] code);
    case (code)
      LR_SLOW: return SLOW_STEP;
      LR_FAST: return FAST_STEP;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/axis_integrator.sv
// One screen axis: adds a signed step to the position and clamps to 0..MAX.
module axis_integrator
  import motion_pkg::*;
#(
  parameter int MAX  = 639,
  parameter int INIT = 320
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [10:0] step,
  output logic [9:0]         pos,
  output logic               clamped
);

  localparam logic signed [10:0] MAX_S  = 11'(MAX);
  localparam logic [9:0]         MAX_P  = 10'(MAX);
  localparam logic [9:0]         INIT_P = 10'(INIT);

  logic signed [10:0] sum;
  logic [9:0]         pos_n;

  // Candidate position with clamp; clamped reported only for an enabled step.
  always_comb begin
    sum     = $signed({1'b0, pos}) + step;
    pos_n   = sum[9:0];
    clamped = 1'b0;
    if (sum < 11'sd0) begin
      pos_n   = '0;
      clamped = enable;
    end else if (sum > MAX_S) begin
      pos_n   = MAX_P;
      clamped = enable;
    end
  end

  // Position register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos <= INIT_P;
    end else if (enable) begin
      pos <= pos_n;
    end
  end

endmodule

// File: rtl/cursor_motion.sv
// Frame-rate cursor integrator: debounces joystick codes, then steps a clamped x/y.
//
//  state | meaning
//  IDLE  | no step applied on the most recent frame tick
//  MOVE  | a step was applied on the most recent frame tick
module cursor_motion
  import motion_pkg::*;
#(
  parameter int X_MAX         = 639,
  parameter int Y_MAX         = 479,
  parameter int X_INIT        = 320,
  parameter int Y_INIT        = 240,
  parameter int STABLE_FRAMES = 2
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [2:0] dir,
  input  logic [2:0] LRdir,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       moving,
  output logic       edge_hit
);

  localparam int             CW       = $clog2(STABLE_FRAMES + 1);
  localparam logic [CW-1:0]  STABLE_C = CW'(STABLE_FRAMES);

  state_t             state, state_n;
  logic [2:0]         dir_c, lr_c;
  logic [5:0]         code, last_code, last_code_n;
  logic [CW-1:0]      stable_cnt, stable_cnt_n;
  logic               apply;
  logic signed [10:0] step_x, step_y;
  logic               clamp_x, clamp_y;

  // Debounce counter, step decision and next state, evaluated only on frame ticks.
  always_comb begin
    dir_c        = dir_clean(dir);
    lr_c         = lr_clean(LRdir);
    code         = {dir_c, lr_c};
    state_n      = state;
    last_code_n  = last_code;
    stable_cnt_n = stable_cnt;
    apply        = 1'b0;
    if (frame_tick) begin
      if (code == last_code) begin
        if (stable_cnt < STABLE_C) stable_cnt_n = stable_cnt + CW'(1);
      end else begin
        stable_cnt_n = CW'(1);
        last_code_n  = code;
      end
      apply   = (stable_cnt_n >= STABLE_C) && (code != '0);
      state_n = apply ? MOVE : IDLE;
    end
    step_y = apply ? dir_step(dir_c) : '0;
    step_x = apply ? lr_step(lr_c)   : '0;
  end

  // State, debounce history and the one-cycle clamp pulse.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state      <= IDLE;
      last_code  <= '0;
      stable_cnt <= '0;
      edge_hit   <= 1'b0;
    end else begin
      state      <= state_n;
      last_code  <= last_code_n;
      stable_cnt <= stable_cnt_n;
      edge_hit   <= apply && (clamp_x || clamp_y);
    end
  end

  assign moving = (state == MOVE);

  axis_integrator #(.MAX(X_MAX), .INIT(X_INIT)) u_x (
    .clk     (sys_clk),
    .reset   (reset),
    .enable  (apply),
    .step    (step_x),
    .pos     (pos_x),
    .clamped (clamp_x)
  );

  axis_integrator #(.MAX(Y_MAX), .INIT(Y_INIT)) u_y (
    .clk     (sys_clk),
    .reset   (reset),
    .enable  (apply),
    .step    (step_y),
    .pos     (pos_y),
    .clamped (clamp_y)
  );

endmodule

// File: tb/tb_cursor_motion.sv
// Scoreboard bench for cursor_motion: stimulus pushes model expectations per cycle,
// an independent monitor pops and compares on the falling edge.
module tb_cursor_motion;

  localparam int STABLE = 2;

  logic       sys_clk = 1'b0;
  logic       reset, frame_tick;
  logic [2:0] dir, LRdir;
  logic [9:0] pos_x, pos_y;
  logic       moving, edge_hit;

  always #5 sys_clk = ~sys_clk;

  cursor_motion dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .dir        (dir),
    .LRdir      (LRdir),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .moving     (moving),
    .edge_hit   (edge_hit)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       mv;
    logic       eh;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: position, run length of the current code, moving flag.
  int m_x = 320, m_y = 240, m_run = 0, m_last = 0;
  bit m_mov = 1'b0;

  function automatic int vstep(input int d);
    case (d)
      1: return -1;
      4: return -4;
      2: return 1;
      3: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int hstep(input int l);
    case (l)
      1: return 1;
      2: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic cmp(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, then queue the post-edge expectation.
  task automatic cycle(input bit rst, input bit tk, input int d, input int l);
    exp_t e;
    bit   eh;
    int   dv, lv, code, nx, ny;
    reset      = rst;
    frame_tick = tk;
    dir        = d[2:0];
    LRdir      = l[2:0];
    eh = 1'b0;
    if (rst) begin
      m_x = 320; m_y = 240; m_run = 0; m_last = 0; m_mov = 1'b0;
    end else if (tk) begin
      dv   = (d > 4) ? 0 : d;
      lv   = (l > 2) ? 0 : l;
      code = dv * 8 + lv;
      if (code == m_last) m_run++;
      else begin
        m_run  = 1;
        m_last = code;
      end
      if (m_run >= STABLE && code != 0) begin
        ny = m_y + vstep(dv);
        nx = m_x + hstep(lv);
        if (ny < 0) begin ny = 0; eh = 1'b1; end
        else if (ny > 479) begin ny = 479; eh = 1'b1; end
        if (nx > 639) begin nx = 639; eh = 1'b1; end
        m_x = nx; m_y = ny; m_mov = 1'b1;
      end else begin
        m_mov = 1'b0;
      end
    end
    e.x  = 10'(m_x);
    e.y  = 10'(m_y);
    e.mv = m_mov;
    e.eh = eh;
    @(posedge sys_clk);
    #1;
    sb_q.push_back(e);
  endtask

  // A few idle cycles with junk inputs (must be ignored), then one tick cycle.
  task automatic tick(input int d, input int l);
    int gap;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) cycle(1'b0, 1'b0, $urandom_range(0, 7), $urandom_range(0, 7));
    cycle(1'b0, 1'b1, d, l);
  endtask

  // Monitor: every falling edge, compare DUT outputs with the oldest expectation.
  always @(negedge sys_clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      cmp("sb_pos_x", int'(pos_x), int'(e.x));
      cmp("sb_pos_y", int'(pos_y), int'(e.y));
      cmp("sb_moving", int'(moving), int'(e.mv));
      cmp("sb_edge_hit", int'(edge_hit), int'(e.eh));
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d, l, n;
    reset = 1'b1; frame_tick = 1'b0; dir = '0; LRdir = '0;
    @(posedge sys_clk);
    #1;
    cycle(1'b1, 1'b0, 0, 0);
    cycle(1'b1, 1'b1, 3, 2);

    // Reset state held with no ticks.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, $urandom_range(0, 7), $urandom_range(0, 7));
    cmp("rst_x", int'(pos_x), 320);
    cmp("rst_y", int'(pos_y), 240);
    cmp("rst_moving", int'(moving), 0);
    cmp("rst_edge", int'(edge_hit), 0);

    // Fast up: first tick only arms the debounce.
    tick(4, 0); cmp("up1_y", int'(pos_y), 240); cmp("up1_mv", int'(moving), 0);
    tick(4, 0); cmp("up2_y", int'(pos_y), 236); cmp("up2_mv", int'(moving), 1);
    tick(4, 0); cmp("up3_y", int'(pos_y), 232);
    tick(0, 0); cmp("stop_mv", int'(moving), 0);

    // Fast right to x=636, then into the right edge twice.
    for (int i = 0; i < 200 && m_x != 636; i++) tick(0, 2);
    cmp("pre_x", int'(pos_x), 636);
    tick(0, 2); cmp("rclamp_x", int'(pos_x), 639); cmp("rclamp_edge", int'(edge_hit), 1);
    cycle(1'b0, 1'b0, 0, 2); cmp("edge_drop", int'(edge_hit), 0);
    tick(0, 2); cmp("rclamp2_x", int'(pos_x), 639); cmp("rclamp2_edge", int'(edge_hit), 1);

    // Code changes restart the debounce.
    tick(1, 0); cmp("chg1_y", int'(pos_y), 232); cmp("chg1_mv", int'(moving), 0);
    tick(2, 0); cmp("chg2_y", int'(pos_y), 232); cmp("chg2_mv", int'(moving), 0);
    tick(2, 0); cmp("chg3_y", int'(pos_y), 233); cmp("chg3_mv", int'(moving), 1);

    // Illegal codes behave as no motion.
    for (int i = 0; i < 4; i++) tick(7, 5);
    cmp("ill_x", int'(pos_x), 639); cmp("ill_y", int'(pos_y), 233); cmp("ill_mv", int'(moving), 0);

    // Reset coincident with a tick while moving down fast.
    tick(3, 0); tick(3, 0); cmp("dn_y", int'(pos_y), 237); cmp("dn_mv", int'(moving), 1);
    cycle(1'b1, 1'b1, 3, 0);
    cmp("mrst_x", int'(pos_x), 320); cmp("mrst_y", int'(pos_y), 240); cmp("mrst_mv", int'(moving), 0);
    tick(3, 0); cmp("post1_y", int'(pos_y), 240); cmp("post1_mv", int'(moving), 0);
    tick(3, 0); cmp("post2_y", int'(pos_y), 244); cmp("post2_mv", int'(moving), 1);

    // Top edge and bottom edge via fast moves.
    for (int i = 0; i < 200 && m_y != 0; i++) tick(4, 0);
    tick(4, 0); cmp("top_y", int'(pos_y), 0); cmp("top_edge", int'(edge_hit), 1);
    for (int i = 0; i < 300 && m_y != 476; i++) tick(3, 0);
    tick(3, 0); cmp("bot_y", int'(pos_y), 479); cmp("bot_edge", int'(edge_hit), 1);

    // Randomized held codes with occasional resets; scoreboard checks every cycle.
    for (int k = 0; k < 40; k++) begin
      d = $urandom_range(0, 7);
      l = $urandom_range(0, 7);
      n = $urandom_range(1, 30);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 99) == 0) cycle(1'b1, 1'($urandom_range(0, 1)), d, l);
        else tick(d, l);
      end
    end

    cycle(1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b0, 0, 0);
    @(negedge sys_clk);
    #1;
    cmp("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
